// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Multiplexed common-anode 7-segment scanner for N_DIGITS digits.
// Each digit owns one slot of SLOT = CLK_HZ/SCAN_HZ cycles. The first GUARD
// cycles of a slot keep every anode off so the previous digit's segments
// cannot ghost onto the next one. After the guard, the anode is lit for a
// brightness-dependent on_time. A frame is N_DIGITS slots. The displayed
// value, decimal points and blanks are captured once per frame, so a frame
// never mixes old and new data.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - at frame capture, also blank leading zero digits
//                           (from the top digit downward, dp off), never
//                           digit 0.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-low
//   din         packed hex nibbles, digit k = din[4k+3:4k], digit 0 rightmost
//   dp_in       decimal point per digit, 1 = lit
//   blank       per-digit blank, 1 = digit dark
//   brightness  PWM level 0..15, sampled at each slot start
//   AN          anode enables, polarity set by AN_ACT_LOW
//   SEG         {dp,g,f,e,d,c,b,a}, polarity set by SEG_ACT_LOW
//   frame_done  one-cycle pulse in the cycle after each frame capture
//
// The brightness latch comes out of reset at 15, so the first slot after
// reset (which has no slot-start edge of its own) runs at full on-time.
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int CLK_HZ      = 16000000,
    parameter int SCAN_HZ     = 1000,
    parameter int GUARD       = 16,
    parameter int AN_ACT_LOW  = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] din,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic [3:0]            brightness,
    output logic [N_DIGITS-1:0]   AN,
    output logic [7:0]            SEG,
    output logic                  frame_done
);

    localparam int SLOT  = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = $clog2(SLOT);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic                  AN_POL   = (AN_ACT_LOW != 0);
    localparam logic                  SEG_POL  = (SEG_ACT_LOW != 0);
    localparam logic [N_DIGITS-1:0]   AN_OFF   = {N_DIGITS{AN_POL}};
    localparam logic [7:0]            SEG_OFF  = {8{SEG_POL}};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SLOT - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Lit cycles after the guard: ((SLOT-GUARD)*(b+1)) >> 4.
    function automatic logic [CNT_W-1:0] on_time_f(input logic [3:0] b);
        int t;
        t = ((SLOT - GUARD) * (int'(b) + 1)) >> 4;
        return CNT_W'(t);
    endfunction

    // Hex decode to output polarity; a blanked digit drives every segment
    // (dp included) inactive.
    function automatic logic [7:0] seg_f(input logic [3:0] nib, input logic dp,
                                         input logic blk);
        logic [6:0] g;
        logic [7:0] s;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        s = blk ? 8'h00 : {dp, g};
        return SEG_POL ? ~s : s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit flagging zero nibbles with dp off; the
    // first nonzero nibble or lit dp ends the run. Digit 0 is never flagged.
    function automatic logic [N_DIGITS-1:0] lead_blank_f(
        input logic [4*N_DIGITS-1:0] d, input logic [N_DIGITS-1:0] p);
        logic [N_DIGITS-1:0] m;
        logic                run;
        m   = '0;
        run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            if (run && (d[4*k +: 4] == 4'h0) && !p[k])
                m[k] = 1'b1;
            else
                run = 1'b0;
        end
        return m;
    endfunction
`endif

    logic [CNT_W-1:0]      slot_cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] sh_din;
    logic [N_DIGITS-1:0]   sh_dp;
    logic [N_DIGITS-1:0]   sh_blank;
    logic [3:0]            bright_q;

    logic [N_DIGITS-1:0]   cap_blank;

`ifdef LEADING_ZERO_BLANK_EN
    assign cap_blank = blank | lead_blank_f(din, dp_in);
`else
    assign cap_blank = blank;
`endif

    logic                  cnt_wrap;
    logic                  frame_wrap;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [IDX_W-1:0]      idx_nxt;
    logic [4*N_DIGITS-1:0] din_nxt;
    logic [N_DIGITS-1:0]   dp_nxt;
    logic [N_DIGITS-1:0]   blank_nxt;
    logic [CNT_W-1:0]      on_time;
    logic                  in_win;
    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  blk_sel;
    logic [N_DIGITS-1:0]   an_act;

    // Everything below looks at the state *after* the coming edge, so the
    // output registers describe the slot position they will be in.
    always_comb begin
        cnt_wrap   = (slot_cnt == CNT_LAST);
        frame_wrap = cnt_wrap && (idx == IDX_LAST);
        cnt_nxt    = cnt_wrap ? '0 : slot_cnt + CNT_W'(1);

        idx_nxt = idx;
        if (frame_wrap)
            idx_nxt = '0;
        else if (cnt_wrap)
            idx_nxt = idx + IDX_W'(1);

        din_nxt   = frame_wrap ? din       : sh_din;
        dp_nxt    = frame_wrap ? dp_in     : sh_dp;
        blank_nxt = frame_wrap ? cap_blank : sh_blank;

        nib_sel = din_nxt[4*idx_nxt +: 4];
        dp_sel  = dp_nxt[idx_nxt];
        blk_sel = blank_nxt[idx_nxt];

        // The window never includes count 0, so bright_q here is always the
        // value latched for the slot being lit.
        on_time = on_time_f(bright_q);
        in_win  = (int'(cnt_nxt) >= GUARD) &&
                  (int'(cnt_nxt) < GUARD + int'(on_time));

        an_act = '0;
        if (in_win && !blk_sel)
            an_act[idx_nxt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt   <= '0;
            idx        <= '0;
            sh_din     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            bright_q   <= 4'hF;
            AN         <= AN_OFF;
            SEG        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            slot_cnt   <= cnt_nxt;
            idx        <= idx_nxt;
            if (frame_wrap) begin
                sh_din   <= din;
                sh_dp    <= dp_in;
                sh_blank <= cap_blank;
            end
            if (cnt_wrap)
                bright_q <= brightness;
            frame_done <= frame_wrap;
            AN         <= an_act ^ AN_OFF;
            // Shadow data is constant within a slot, so reloading every
            // cycle only changes SEG at slot starts (and on the first edge
            // after reset, where no slot start precedes digit 0).
            SEG        <= seg_f(nib_sel, dp_sel, blk_sel);
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int ND      = 4;
    localparam int CLK_HZ  = 1600;
    localparam int SCAN_HZ = 100;
    localparam int GUARD   = 2;
    localparam int SLOT    = CLK_HZ / SCAN_HZ;
    localparam int FRAME   = SLOT * ND;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  brightness = 4'hF;
    logic [3:0]  AN;
    logic [7:0]  SEG;
    logic        frame_done;

    seg7_scan_ctrl #(
        .N_DIGITS(ND), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .GUARD(GUARD),
        .AN_ACT_LOW(1), .SEG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .blank(blank),
        .brightness(brightness), .AN(AN), .SEG(SEG), .frame_done(frame_done)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nerr = 0;
    int   mdl_n = 0;
    logic done = 1'b0;

    // Active-low glyphs with dp off.
    logic [7:0] seg_lo [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [3:0] lead_blank(input logic [15:0] d, input logic [3:0] p);
        logic [3:0] m;
        int top;
        m   = 4'h0;
        top = 0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 1; k < ND; k++)
            if (d[4*k +: 4] != 4'h0 || p[k]) top = k;
        for (int k = top + 1; k < ND; k++) m[k] = 1'b1;
`endif
        return m;
    endfunction

    // Reference model: position in the scan follows from the number of clock
    // edges since reset; the frame contents are whatever was on the inputs at
    // the most recent frame boundary.
    initial begin : model
        logic [15:0] f_din;
        logic [3:0]  f_dp, f_blank, f_br, nib;
        logic [7:0]  sg;
        int          s, k, on;
        exp_t        e;
        f_din = '0; f_dp = '0; f_blank = '0; f_br = 4'hF;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mdl_n = 0;
                f_din = '0; f_dp = '0; f_blank = '0; f_br = 4'hF;
            end else begin
                mdl_n++;
                s = mdl_n % SLOT;
                k = (mdl_n / SLOT) % ND;
                e.fd = (mdl_n % FRAME == 0);
                if (e.fd) begin
                    f_din   = din;
                    f_dp    = dp_in;
                    f_blank = blank | lead_blank(din, dp_in);
                end
                if (s == 0) f_br = brightness;
                on = ((SLOT - GUARD) * (int'(f_br) + 1)) / 16;
                e.an = 4'hF;
                if (!f_blank[k] && s >= GUARD && s < GUARD + on) e.an[k] = 1'b0;
                nib = f_din[4*k +: 4];
                sg  = seg_lo[nib];
                if (f_dp[k]) sg[7] = 1'b0;
                e.seg = f_blank[k] ? 8'hFF : sg;
                q.push_back(e);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        nchk++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s t=%0t n=%0d: got %h, want %h", nm, $time, mdl_n, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or negedge rst);
            #1;
            if (!rst) begin
                chk("reset_an", {4'h0, AN}, 8'h0F);
                chk("reset_seg", SEG, 8'hFF);
                chk("reset_fd", {7'h0, frame_done}, 8'h00);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                chk("an", {4'h0, AN}, {4'h0, e.an});
                chk("seg", SEG, e.seg);
                chk("frame_done", {7'h0, frame_done}, {7'h0, e.fd});
            end
            if (done) break;
        end
        chk("queue_drained", 8'(q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    task automatic cycles(input int c);
        repeat (c) @(negedge clk);
    endtask

    // Bounded wait for a scan position; gives up after one frame.
    task automatic wait_phase(input int ph);
        for (int i = 0; i < FRAME && (mdl_n % FRAME) != ph; i++) @(negedge clk);
    endtask

    initial begin : stim
        rst = 1'b0; din = 16'h4321; dp_in = 4'h0; blank = 4'h0; brightness = 4'hF;
        cycles(3);
        rst = 1'b1;
        cycles(2 * FRAME);
        brightness = 4'd7;  cycles(FRAME);
        brightness = 4'd0;  cycles(FRAME);
        brightness = 4'd15; cycles(FRAME);

        // Mid-frame data change while digit 1 is showing.
        wait_phase(SLOT + 5);
        din = 16'h8888;
        cycles(2 * FRAME);

        din = 16'h4321; blank = 4'b0100; dp_in = 4'b0001;
        cycles(2 * FRAME);
        blank = 4'h0; dp_in = 4'h0;

`ifdef LEADING_ZERO_BLANK_EN
        din = 16'h0050; cycles(2 * FRAME);
        din = 16'h0000; cycles(2 * FRAME);
`endif

        repeat (30 * FRAME) begin
            @(negedge clk);
            if ($urandom_range(15) == 0) begin
                case ($urandom_range(3))
                    0: din        = 16'($urandom);
                    1: dp_in      = 4'($urandom);
                    2: blank      = 4'($urandom_range(15)) & 4'($urandom_range(15));
                    default: brightness = 4'($urandom);
                endcase
            end
        end

        // Asynchronous reset while digit 2 is lit.
        din = 16'h1234; blank = 4'h0; dp_in = 4'h0; brightness = 4'hF;
        cycles(2 * FRAME);
        wait_phase(2 * SLOT + 8);
        #2 rst = 1'b0;
        cycles(3);
        rst = 1'b1;
        cycles(2 * FRAME);
        done = 1'b1;
    end

endmodule
